bram_stream_reader: RTL
=======================

Name: bram_stream_reader

Overview:
- Read-side master for the pseudo-dual-port block RAM.
- On a start command, it reads `length` consecutive words starting at `base_addr` and presents them on a valid/ready output stream, one word per cycle at full throughput.
- The BRAM's 1-cycle registered read latency is absorbed by using the BRAM output register as the stream data register. Its lock input holds the data under backpressure.
- Sits between the BRAM read port and downstream consumers (DMA packer, AXI write engine).

Parameters:
- ADDR_WIDTH, 16, BRAM address width.
- DATA_WIDTH, 128, BRAM/stream word width.
- MEM_DEPTH, 'h4000, number of BRAM words; addresses wrap at MEM_DEPTH.
- LEN_WIDTH, 17, width of the transfer length (allows 0..MEM_DEPTH words).

Ports:
- clk  in  1  clock; all logic is posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle command strobe; honoured only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address, sampled with start.
- length  in  LEN_WIDTH  word count, sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final word handshake, or after a zero-length command.
- bram_rden  out  1  BRAM read enable (combinational).
- bram_rdaddr  out  ADDR_WIDTH  BRAM read address (equals the address counter).
- bram_lock  out  1  BRAM output hold (combinational).
- bram_rddata  in  DATA_WIDTH  BRAM registered read data.
- m_valid  out  1  stream word valid (registered).
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  equals bram_rddata (pass-through, no extra register).
- m_last  out  1  marks the final word of the transfer (registered).

Behaviour:
- Reset values: state=IDLE, m_valid=0, m_last=0, busy=0, done=0, addr=0, remaining=0.
  - bram_rden=0 and bram_lock=0 whenever state=IDLE or rst=1.
- States:
  - IDLE: start and length!=0 → RUN; load addr=base_addr, remaining=length.
  - IDLE: start and length==0 → stay in IDLE, pulse done next cycle, no BRAM access.
  - RUN: words still to issue. Move to DRAIN in the cycle the last read issues (remaining==1 and issue).
  - DRAIN: all reads issued. Move to IDLE when the last word handshakes (m_valid & m_ready & m_last), and pulse done in the next cycle.
- Pipeline control:
  - advance = !m_valid | m_ready.
  - issue = (state==RUN) & advance.
  - bram_rden = issue.
  - bram_lock = m_valid & !m_ready.
  - bram_rden and bram_lock are never both high.
- Register updates:
  - On issue: addr <= (addr==MEM_DEPTH-1) ? 0 : addr+1; remaining <= remaining-1; m_valid <= 1; m_last <= (remaining==1).
  - On advance without issue: m_valid <= 0, m_last <= 0.
- Latency and throughput:
  - First read issues 1 cycle after start; first m_valid 2 cycles after start.
  - With m_ready tied high, one word is delivered per cycle with no bubbles; done follows the last handshake by 1 cycle.
- Backpressure: while m_ready=0 with m_valid=1, the BRAM holds rddata via lock, and m_data stays stable. No read issues and addr is frozen.
- Address wrap: base_addr+length > MEM_DEPTH wraps to 0 at MEM_DEPTH.
- Other boundary conditions:
  - start while busy is ignored; the sampled values are unchanged.
  - rst asserted mid-transfer takes effect next edge: IDLE, m_valid=0, no done pulse. The in-flight word is discarded.
  - Downstream sees m_valid drop in the same cycle. Consumers must tolerate an aborted packet without m_last.
- done and start in the same cycle: the start is accepted, because state is IDLE at that point.

Decomposition:
- Package bram_stream_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
  - localparam defaults for ADDR_WIDTH/DATA_WIDTH/MEM_DEPTH, shared with the BRAM instance.
- No sub-module is needed inside the block. The testbench instantiates the existing pseudo-dual-port BRAM as the read target and back-loads it through its write port.

Test Plan:
- Preload mem[i]=i for i=0..15. Send start with base_addr=4, length=8, m_ready=1 → m_data 4..11 on 8 consecutive cycles, first valid 2 cycles after start. m_last is on word 11; done pulses 1 cycle later.
- Same transfer with m_ready toggled 1,0,0,1 repeating → every word delivered exactly once, in order. m_data stable while stalled, and bram_lock high exactly when m_valid & !m_ready.
- MEM_DEPTH=16, base_addr=14, length=4 → words from addresses 14, 15, 0, 1.
- length=0 → done pulse 1 cycle after start, bram_rden never asserted, m_valid stays 0.
- Assert rst 3 cycles into a length=10 transfer → next cycle m_valid=0, busy=0, no done. A following start with base_addr=0, length=2 then yields words 0 and 1 normally.
- Send a second start while busy with different base_addr → ignored. The original transfer completes unchanged and only one done pulse occurs.

Source files
------------

// File: rtl/bram_stream_pkg.sv
// Shared types and default geometry for the BRAM stream reader and its BRAM instance.
package bram_stream_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_MEM_DEPTH  = 'h4000;
  localparam int DEF_LEN_WIDTH  = 17;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready word stream carrying BRAM read data to a downstream consumer.
interface bram_stream_reader_if
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/bram_stream_reader.sv
// Streams `length` consecutive BRAM words from `base_addr`; the BRAM output register
// doubles as the stream data register and is frozen through bram_lock under backpressure.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_rden,
  output logic [ADDR_WIDTH-1:0] bram_rdaddr,
  output logic                  bram_lock,
  input  logic [DATA_WIDTH-1:0] bram_rddata,
  bram_stream_reader_if.master  m
);

  rd_state_t             state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  advance;
  logic                  issue;
  logic                  last_hs;

  // The output slot is free when empty or being drained this cycle.
  assign advance = !m.m_valid || m.m_ready;
  assign issue   = (state == RUN) && advance && !rst;
  assign last_hs = m.m_valid && m.m_ready && m.m_last;

  assign bram_rden   = issue;
  assign bram_rdaddr = addr;
  assign bram_lock   = m.m_valid && !m.m_ready && (state != IDLE) && !rst;
  assign m.m_data    = bram_rddata;

  // NOTE: state registers use non-blocking assignments so every read in this block
  // sees the pre-edge value, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      m.m_valid <= 1'b0;
      m.m_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (issue) begin
        addr      <= (addr == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr + 1'b1;
        remaining <= remaining - 1'b1;
        m.m_valid <= 1'b1;
        m.m_last  <= (remaining == LEN_WIDTH'(1));
      end else if (advance) begin
        m.m_valid <= 1'b0;
        m.m_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              state     <= RUN;
              addr      <= base_addr;
              remaining <= length;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && remaining == LEN_WIDTH'(1)) state <= DRAIN;
        end
        DRAIN: begin
          if (last_hs) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
